// File: rtl/xcrazy_pkg.sv
// Shared definitions for the Gigatron extension CPLD SPI path.
// Contents:
//   spi_state_t   - byte engine FSM encoding (IDLE / LOW / HIGH)
//   MOSI_IDLE     - level MOSI rests at between transfers
//   CTRL_SPI_SEND - ctrl code the decoder matches to pulse `start`
//   is_spi_send() - helper for the decoder's ctrl-code match
package xcrazy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOW  = 2'b01,
    ST_HIGH = 2'b10
  } spi_state_t;

  localparam logic       MOSI_IDLE     = 1'b1;
  localparam logic [7:0] CTRL_SPI_SEND = 8'hF0;

  function automatic logic is_spi_send(input logic [7:0] code);
    return code == CTRL_SPI_SEND;
  endfunction

endpackage

// File: rtl/spi_byte_engine_if.sv
// Command/readback bundle between the ctrl-code decoder / readback mux
// (master) and the SPI byte engine (slave).
//   start - request a transfer (engine honours it only while idle)
//   txd   - byte to send, captured with start
//   div   - SCK half-period minus one, captured with start
//   busy  - transfer in progress
//   done  - one-cycle completion pulse
//   rxd   - last received byte
interface spi_byte_engine_if #(
  parameter int DIVW = 4
);
  logic            start;
  logic [7:0]      txd;
  logic [DIVW-1:0] div;
  logic            busy;
  logic            done;
  logic [7:0]      rxd;

  modport master (output start, txd, div, input busy, done, rxd);
  modport slave  (input start, txd, div, output busy, done, rxd);
endinterface

// File: rtl/spi_byte_engine_halfdiv.sv
// SCK half-period counter for the SPI byte engine.
//   CLKx4  - clock
//   nRESET - asynchronous reset, active-low
//   load   - clear the count (transfer accepted)
//   en     - count this cycle (engine is in LOW or HIGH)
//   divr   - latched half-period minus one
//   tick   - current cycle is the last one of the half-period
module spi_halfdiv #(
  parameter int DIVW = 4
) (
  input  logic            CLKx4,
  input  logic            nRESET,
  input  logic            load,
  input  logic            en,
  input  logic [DIVW-1:0] divr,
  output logic            tick
);

  logic [DIVW-1:0] hcnt_reg;

  // Comparing against divr and restarting at 0 means the count never
  // passes divr, so no wrap handling is needed for any div value.
  assign tick = en && (hcnt_reg == divr);

  always_ff @(posedge CLKx4 or negedge nRESET) begin
    if (!nRESET) begin
      hcnt_reg <= '0;
    end else if (load) begin
      hcnt_reg <= '0;
    end else if (en) begin
      hcnt_reg <= tick ? '0 : hcnt_reg + DIVW'(1);
    end
  end

endmodule

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte shifter: one `start` sends txd MSB first on MOSI while
// capturing MISO; the received byte appears on rxd with a done pulse.
//   CLKx4  - 25 MHz clock, only clock
//   nRESET - asynchronous reset, active-low
//   bus    - command/readback bundle (start, txd, div, busy, done, rxd)
//   miso   - muxed MISO from the top level
//   MOSI   - serial data out (idles high)
//   SCK    - SPI clock, CPOL=0
module spi_byte_engine
  import xcrazy_pkg::*;
#(
  parameter int DIVW = 4
) (
  input  logic                    CLKx4,
  input  logic                    nRESET,
  spi_byte_engine_if.slave        bus,
  input  logic                    miso,
  output logic                    MOSI,
  output logic                    SCK
);

  spi_state_t      state_reg;
  logic [7:0]      shreg_reg;
  logic [DIVW-1:0] divr_reg;
  logic [2:0]      bitcnt_reg;
  logic            rbit_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [7:0]      rxd_reg;

  logic accept;
  logic tick;

  assign accept = (state_reg == ST_IDLE) && bus.start;

  spi_halfdiv #(.DIVW(DIVW)) u_halfdiv (
    .CLKx4  (CLKx4),
    .nRESET (nRESET),
    .load   (accept),
    .en     (state_reg != ST_IDLE),
    .divr   (divr_reg),
    .tick   (tick)
  );

  always_ff @(posedge CLKx4 or negedge nRESET) begin
    if (!nRESET) begin
      state_reg  <= ST_IDLE;
      shreg_reg  <= 8'h00;
      divr_reg   <= '0;
      bitcnt_reg <= 3'd0;
      rbit_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      rxd_reg    <= 8'h00;
      SCK        <= 1'b0;
      MOSI       <= MOSI_IDLE;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            shreg_reg  <= bus.txd;
            divr_reg   <= bus.div;
            MOSI       <= bus.txd[7];
            bitcnt_reg <= 3'd0;
            busy_reg   <= 1'b1;
            state_reg  <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (tick) begin
            // MISO is sampled on the same edge that raises SCK
            SCK       <= 1'b1;
            rbit_reg  <= miso;
            state_reg <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (tick) begin
            SCK        <= 1'b0;
            shreg_reg  <= {shreg_reg[6:0], rbit_reg};
            bitcnt_reg <= bitcnt_reg + 3'd1;
            if (bitcnt_reg == 3'd7) begin
              rxd_reg   <= {shreg_reg[6:0], rbit_reg};
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              MOSI      <= MOSI_IDLE;
              state_reg <= ST_IDLE;
            end else begin
              // shreg[6] becomes the new MSB after this shift
              MOSI      <= shreg_reg[6];
              state_reg <= ST_LOW;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.rxd  = rxd_reg;

endmodule
